// File: rtl/serial_digit_adder.sv
// serial_digit_adder: digit-serial adder/subtractor, DIGIT bits per clock, LSB digit first.
// Ports: clk, rst (sync, active high); start/sub/a/b/cin are captured when idle or done;
// busy is high during the N compute cycles, done pulses once with sum/cout/overflow valid.
// cout is the raw MSB carry (1 = no borrow when subtracting); overflow is signed overflow.
module serial_digit_adder #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);
    localparam int N = WIDTH / DIGIT;
    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q;
    logic [IW-1:0] idx_q;
    logic [WIDTH-1:0] a_q, b_q, sum_q;
    logic carry_q, busy_q, done_q, cout_q, ovf_q;
    logic [DIGIT-1:0] dig_a, dig_b, dig_s;
    logic dig_c, msb_c, take;
    always_comb begin
        dig_a = a_q[idx_q * DIGIT +: DIGIT];
        dig_b = b_q[idx_q * DIGIT +: DIGIT];
        {dig_c, dig_s} = {1'b0, dig_a} + {1'b0, dig_b} + (DIGIT + 1)'(carry_q);
        // carry into the digit's top bit, recovered from its sum bit
        msb_c = dig_s[DIGIT-1] ^ dig_a[DIGIT-1] ^ dig_b[DIGIT-1];
        take = start && state_q != RUN;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else if (take) begin
            state_q <= RUN;
            idx_q   <= '0;
            a_q     <= a;
            // subtract as a + ~b + ~cin
            b_q     <= b ^ {WIDTH{sub}};
            carry_q <= cin ^ sub;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
        end else if (state_q == RUN) begin
            sum_q[idx_q * DIGIT +: DIGIT] <= dig_s;
            carry_q <= dig_c;
            idx_q   <= idx_q + 1'b1;
            if (idx_q == LAST) begin
                state_q <= DONE;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
                cout_q  <= dig_c;
                ovf_q   <= msb_c ^ dig_c;
            end
        end else begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;
endmodule
